nibble_serializer: RTL

Downstream consumer of the replicated-word/slice stage. It takes the 8-bit word together with its upper and lower 4-bit slices, and checks that the slices match the word. Words are buffered in a small FIFO and emitted as two 4-bit nibbles over a valid/ready stream. The block also keeps a completed-word count and a sticky slice-mismatch flag for debug.

---
 rtl/nibble_serializer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_serializer.sv
// Buffers 8-bit words in a small FIFO and streams each one out as two 4-bit
// nibbles over valid/ready, with a sticky slice-mismatch flag and a word count.
module nibble_serializer #(
  parameter int DEPTH     = 2,
  parameter bit MSN_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_a,
  input  logic [3:0]               i_a1,
  input  logic [3:0]               i_a2,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [3:0]               o_nib,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_mismatch,
  output logic [CNT_W-1:0]         o_word_cnt,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic [7:0]       r_word;
  logic [7:0]       w_word_nxt;
  logic [3:0]       r_nib;
  logic [3:0]       w_nib_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_done;

  function automatic logic slice_mismatch(input logic [7:0] word,
                                          input logic [3:0] hi,
                                          input logic [3:0] lo);
    return (hi != word[7:4]) || (lo != word[3:0]);
  endfunction

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
  assign o_ready = (r_level < FULL) && i_rst_n;
  assign w_push  = i_valid && o_ready;

  // Output sequencer: pick up the FIFO head, walk it through both nibbles.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_word_nxt  = r_mem[r_rd_ptr];
          w_state_nxt = ST_FIRST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIRST: begin
        if (i_ready) begin
          w_state_nxt = ST_SECOND;
        end else begin
          w_state_nxt = ST_FIRST;
        end
      end
      ST_SECOND: begin
        if (i_ready) begin
          w_done = 1'b1;
          if (r_level != '0) begin
            w_pop       = 1'b1;
            w_word_nxt  = r_mem[r_rd_ptr];
            w_state_nxt = ST_FIRST;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_SECOND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops already aligned.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_nib_nxt   = 4'h0;
    case (w_state_nxt)
      ST_FIRST: begin
        w_valid_nxt = 1'b1;
        w_nib_nxt   = MSN_FIRST ? w_word_nxt[7:4] : w_word_nxt[3:0];
      end
      ST_SECOND: begin
        w_valid_nxt = 1'b1;
        w_last_nxt  = 1'b1;
        w_nib_nxt   = MSN_FIRST ? w_word_nxt[3:0] : w_word_nxt[7:4];
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Occupancy bookkeeping.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO storage; never reset, occupancy alone decides what is live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_a;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_word     <= 8'h00;
      r_nib      <= 4'h0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_mismatch <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_level <= w_level_nxt;
      r_nib   <= w_nib_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && slice_mismatch(i_a, i_a1, i_a2)) begin
        r_mismatch <= 1'b1;
      end
      if (w_done) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  assign o_nib      = r_nib;
  assign o_last     = r_last;
  assign o_valid    = r_valid;
  assign o_mismatch = r_mismatch;
  assign o_word_cnt = r_word_cnt;
  assign o_level    = r_level;

endmodule
